// File: rtl/sram64x128_ctrl.sv
// Initiator-side controller for a 64x128 single-port SRAM macro: request/response
// streams to registered CSB/WEB/OEB/A/I pin sequences, plus a zero-fill sweep.
module sram64x128_ctrl #(
    parameter int AW = 6,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    output logic [AW-1:0] sram_A,
    output logic [DW-1:0] sram_I,
    output logic          sram_CSB,
    output logic          sram_WEB,
    output logic          sram_OEB,
    input  logic [DW-1:0] sram_O
);

    // state     | meaning
    // S_IDLE    | no SRAM access this cycle, ready for a request
    // S_WR      | write pins driven this cycle, another request may follow
    // S_RD_ISS  | read pins driven this cycle, SRAM latches at next edge
    // S_RD_WAIT | OEB low, sram_O captured at next edge
    // S_RESP    | read data held on the response port until accepted
    // S_CLR     | zero-fill sweep, one word per cycle
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_ISS,
        S_RD_WAIT,
        S_RESP,
        S_CLR
    } state_t;

    state_t        state_q, state_d;
    logic          csb_q, csb_d;
    logic          web_q, web_d;
    logic          oeb_q, oeb_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] i_q, i_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          clr_done_q, clr_done_d;
    logic          accept;

    assign req_ready = rst_n && (state_q == S_IDLE || state_q == S_WR) && !clr_start;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        csb_d       = csb_q;
        web_d       = web_q;
        oeb_d       = oeb_q;
        a_d         = a_q;
        i_d         = i_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        clr_done_d  = 1'b0;
        unique case (state_q)
            S_IDLE, S_WR: begin
                if (clr_start) begin
                    state_d = S_CLR;
                    csb_d   = 1'b0;
                    web_d   = 1'b0;
                    a_d     = '0;
                    i_d     = '0;
                    cnt_d   = '0;
                end else if (accept && req_we) begin
                    state_d = S_WR;
                    csb_d   = 1'b0;
                    web_d   = 1'b0;
                    a_d     = req_addr;
                    i_d     = req_wdata;
                end else if (accept) begin
                    state_d = S_RD_ISS;
                    csb_d   = 1'b0;
                    web_d   = 1'b1;
                    a_d     = req_addr;
                end else begin
                    state_d = S_IDLE;
                    csb_d   = 1'b1;
                    web_d   = 1'b1;
                end
            end
            S_RD_ISS: begin
                state_d = S_RD_WAIT;
                csb_d   = 1'b1;
                oeb_d   = 1'b0;
            end
            S_RD_WAIT: begin
                state_d     = S_RESP;
                oeb_d       = 1'b1;
                rsp_valid_d = 1'b1;
                rdata_d     = sram_O;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            S_CLR: begin
                // cnt_q always equals the address being cleared this cycle
                if (cnt_q == {AW{1'b1}}) begin
                    state_d    = S_IDLE;
                    csb_d      = 1'b1;
                    web_d      = 1'b1;
                    cnt_d      = '0;
                    clr_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    a_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                csb_d   = 1'b1;
                web_d   = 1'b1;
                oeb_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            oeb_q       <= 1'b1;
            a_q         <= '0;
            i_q         <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            clr_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            oeb_q       <= oeb_d;
            a_q         <= a_d;
            i_q         <= i_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            clr_done_q  <= clr_done_d;
        end
    end

    assign sram_CSB  = csb_q;
    assign sram_WEB  = web_q;
    assign sram_OEB  = oeb_q;
    assign sram_A    = a_q;
    assign sram_I    = i_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign clr_busy  = (state_q == S_CLR);
    assign clr_done  = clr_done_q;

endmodule

// File: tb/tb_sram64x128_ctrl.sv
// Bench for sram64x128_ctrl: SRAM macro model, transaction-level reference
// model with per-cycle pin compare, directed scenarios and random traffic.
module tb_sram64x128_ctrl;
    localparam int AW    = 6;
    localparam int DW    = 128;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          clr_start = 1'b0;
    logic          clr_busy;
    logic          clr_done;
    logic [AW-1:0] sram_A;
    logic [DW-1:0] sram_I;
    logic          sram_CSB;
    logic          sram_WEB;
    logic          sram_OEB;
    logic [DW-1:0] sram_O;

    always #5 clk = ~clk;

    sram64x128_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .sram_A(sram_A), .sram_I(sram_I), .sram_CSB(sram_CSB),
        .sram_WEB(sram_WEB), .sram_OEB(sram_OEB), .sram_O(sram_O)
    );

    // SRAM macro: synchronous access on clk, output floats (junk here) when OEB=1
    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] sram_dout;
    always @(posedge clk) begin
        if (!sram_CSB) begin
            if (!sram_WEB) sram_mem[sram_A] <= sram_I;
            else           sram_dout <= sram_mem[sram_A];
        end
    end
    assign sram_O = sram_OEB ? {4{32'hDEADBEEF}} : sram_dout;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
        end
    endtask

    // Reference model: memory contents plus a timeline of the access in flight
    logic [DW-1:0] ref_mem [DEPTH];
    bit            model_on   = 0;
    bit            wr_act     = 0;
    logic [AW-1:0] wr_addr    = '0;
    logic [DW-1:0] wr_data    = '0;
    int            rd_age     = -1;
    logic [AW-1:0] rd_addr    = '0;
    logic [DW-1:0] rd_exp     = '0;
    int            sweep      = -1;
    bit            done_exp   = 0;
    bit            ai_zero    = 0;
    bit            rdata_zero = 0;

    always @(posedge clk) begin
        done_exp = 0;
        if (wr_act)     ref_mem[wr_addr] = wr_data;
        if (sweep >= 0) ref_mem[sweep] = '0;
        if (!rst_n) begin
            model_on   = 1;
            wr_act     = 0;
            rd_age     = -1;
            sweep      = -1;
            ai_zero    = 1;
            rdata_zero = 1;
        end else if (model_on) begin
            if (sweep >= 0) begin
                if (sweep == DEPTH - 1) begin
                    sweep    = -1;
                    done_exp = 1;
                end else begin
                    sweep++;
                end
            end else if (rd_age >= 0) begin
                if (rd_age < 2) begin
                    rd_age++;
                    if (rd_age == 2) rdata_zero = 0;
                end else if (rsp_ready) begin
                    rd_age = -1;
                end
            end else begin
                wr_act = 0;
                if (clr_start) begin
                    sweep   = 0;
                    ai_zero = 0;
                end else if (req_valid && req_we) begin
                    wr_act  = 1;
                    wr_addr = req_addr;
                    wr_data = req_wdata;
                    ai_zero = 0;
                end else if (req_valid) begin
                    rd_age  = 0;
                    rd_addr = req_addr;
                    rd_exp  = ref_mem[req_addr];
                    ai_zero = 0;
                end
            end
        end
    end

    int csb_low_n = 0;
    int busy_n    = 0;
    int done_n    = 0;

    always @(negedge clk) begin
        if (model_on) begin
            logic e_csb, e_web, e_oeb;
            e_csb = !(wr_act || rd_age == 0 || sweep >= 0);
            e_web = !(wr_act || sweep >= 0);
            e_oeb = !(rd_age == 1);
            chk("csb", sram_CSB, e_csb);
            chk("web", sram_WEB, e_web);
            chk("oeb", sram_OEB, e_oeb);
            chk("req_ready", req_ready, rst_n && rd_age < 0 && sweep < 0 && !clr_start);
            chk("rsp_valid", rsp_valid, rd_age == 2);
            chk("clr_busy", clr_busy, sweep >= 0);
            chk("clr_done", clr_done, done_exp);
            if (rd_age == 2) chk("rsp_rdata", rsp_rdata, rd_exp);
            if (rdata_zero)  chk("rsp_rdata_reset", rsp_rdata, '0);
            if (!e_csb) chk("sram_A", sram_A, wr_act ? wr_addr : (rd_age == 0 ? rd_addr : 6'(sweep)));
            if (!e_web) chk("sram_I", sram_I, wr_act ? wr_data : '0);
            if (ai_zero) begin
                chk("sram_A_reset", sram_A, '0);
                chk("sram_I_reset", sram_I, '0);
            end
        end
        if (sram_CSB === 1'b0) csb_low_n++;
        if (clr_busy === 1'b1) busy_n++;
        if (clr_done === 1'b1) done_n++;
    end

    int last_acc = 0;

    task automatic send(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok = 0;
        req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
        for (int n = 0; n < 200 && !ok; n++) begin
            #1 ok = req_ready;
            @(posedge clk); #1;
        end
        req_valid = 0;
        last_acc  = cyc;
        chk("send_accepted", ok, 1);
    endtask

    task automatic get_rsp(output logic [DW-1:0] data, output int seen);
        bit got = 0;
        data = '0;
        seen = -1;
        for (int n = 0; n < 50 && !got; n++) begin
            if (rsp_valid) begin
                got  = 1;
                data = rsp_rdata;
                seen = cyc;
            end
            @(posedge clk); #1;
        end
        chk("rsp_arrived", got, 1);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
        logic [DW-1:0] d;
        int            w;
        send(0, a, '0);
        get_rsp(d, w);
        chk(name, d, exp);
    endtask

    task automatic fill_ones();
        for (int a = 0; a < DEPTH; a++) send(1, 6'(a), '1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        int            w, t0, c0, b0, dn0;

        // reset held two cycles with a request pending
        req_valid = 1; req_we = 1; req_addr = 6'd9;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", req_ready, 0);
        chk("reset_csb", sram_CSB, 1);
        chk("reset_oeb", sram_OEB, 1);
        req_valid = 0;
        rst_n = 1;
        @(posedge clk); #1;
        chk("post_reset_web", sram_WEB, 1);
        chk("post_reset_rsp_valid", rsp_valid, 0);
        chk("post_reset_clr_busy", clr_busy, 0);

        // write then read same address in consecutive cycles
        c0 = csb_low_n;
        send(1, 6'd5, {16{8'hA5}});
        send(0, 6'd5, '0);
        t0 = last_acc;
        get_rsp(d, w);
        chk("wr_rd_data", d, {16{8'hA5}});
        chk("wr_rd_latency", 32'(w - t0), 32'd2);
        repeat (2) @(posedge clk);
        #1 chk("wr_rd_csb_cycles", 32'(csb_low_n - c0), 32'd2);

        // back-to-back writes, one per cycle
        send(1, 6'd0, '0);
        t0 = last_acc;
        for (int a = 1; a < DEPTH; a++) send(1, 6'(a), DW'(a * 3));
        chk("b2b_cycles", 32'(last_acc - t0), 32'd63);
        rd(6'd63, 128'd189, "rd63");
        rd(6'd0, 128'd0, "rd0");

        // response backpressure
        rsp_ready = 0;
        send(0, 6'd7, '0);
        for (int n = 0; n < 10 && !rsp_valid; n++) begin
            @(posedge clk); #1;
        end
        for (int n = 0; n < 5; n++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_rdata, 128'd21);
            chk("bp_ready", req_ready, 0);
            chk("bp_oeb", sram_OEB, 1);
            @(posedge clk); #1;
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        chk("bp_release_valid", rsp_valid, 0);
        chk("bp_release_ready", req_ready, 1);

        // sweep beats a same-cycle request
        fill_ones();
        clr_start = 1; req_valid = 1; req_we = 1; req_addr = 6'd9; req_wdata = 128'd5;
        #1 chk("clr_beats_req", req_ready, 0);
        b0 = busy_n; dn0 = done_n;
        @(posedge clk); #1;
        clr_start = 0; req_valid = 0;
        repeat (70) @(posedge clk);
        #1;
        chk("clr_busy_cycles", 32'(busy_n - b0), 32'd64);
        chk("clr_done_pulses", 32'(done_n - dn0), 32'd1);
        rd(6'd0, '0, "clr_rd0");
        rd(6'd31, '0, "clr_rd31");
        rd(6'd63, '0, "clr_rd63");
        rd(6'd9, '0, "clr_rd9");

        // reset during read wait
        send(0, 6'd3, '0);
        @(posedge clk); #1;
        chk("rdwait_oeb", sram_OEB, 0);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        chk("rst_rdwait_valid", rsp_valid, 0);
        chk("rst_rdwait_oeb", sram_OEB, 1);
        @(posedge clk); #1;
        chk("rst_rdwait_ready", req_ready, 1);

        // reset in the middle of a sweep
        fill_ones();
        clr_start = 1;
        @(posedge clk); #1;
        clr_start = 0;
        dn0 = done_n;
        repeat (20) @(posedge clk);
        #1 chk("sweep_at20", sram_A, 128'd20);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        chk("rst_sweep_busy", clr_busy, 0);
        repeat (3) @(posedge clk);
        #1 chk("rst_sweep_no_done", 32'(done_n - dn0), 32'd0);
        rd(6'd19, '0, "rst_sweep_rd19");
        rd(6'd21, '1, "rst_sweep_rd21");

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            req_valid = ($urandom % 3) != 0;
            req_we    = $urandom % 2;
            req_addr  = 6'($urandom);
            req_wdata = {$urandom, $urandom, $urandom, $urandom};
            rsp_ready = ($urandom % 4) != 0;
            clr_start = ($urandom % 150) == 0;
            rst_n     = ($urandom % 600) != 0;
            @(posedge clk); #1;
        end
        req_valid = 0; clr_start = 0; rsp_ready = 1; rst_n = 1;
        repeat (80) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
